// File: rtl/ds_operand_stage.sv
// ds_operand_stage: decode-stage operand unit for the five-stage LoongArch pipeline.
// Holds one decoded instruction in a valid/allowin slot and resolves NUM_SRC source
// operands from an NUM_FWD-deep priority forwarding network or the register file.
// Interlocks on forwarded values that are not final, honours flush, and counts
// interlock cycles in a saturating counter.
// Configuration macro FWD_EN: defined = full forwarding from every network index;
// undefined = only the WB index (NUM_FWD-1) is bypassed, any younger hit interlocks.
module ds_operand_stage #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_SRC   = 2,
  parameter int NUM_FWD   = 3,
  parameter int PAYLOAD_W = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_allowin,
  input  logic [PAYLOAD_W-1:0]        in_payload,
  input  logic [NUM_SRC*ADDR_W-1:0]   in_raddr,
  input  logic [NUM_SRC-1:0]          in_need,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_allowin,
  output logic [PAYLOAD_W-1:0]        out_payload,
  output logic [NUM_SRC*DATA_W-1:0]   out_rdata,
  output logic [NUM_SRC*ADDR_W-1:0]   rf_raddr,
  input  logic [NUM_SRC*DATA_W-1:0]   rf_rdata,
  input  logic [NUM_FWD-1:0]          fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0]   fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
  input  logic [NUM_FWD-1:0]          fwd_ready,
  output logic [31:0]                 stall_cnt
);

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned WB_IDX  = NUM_FWD - 1;

  // Slot state
  logic                       r_valid;
  logic [PAYLOAD_W-1:0]       r_payload;
  logic [NUM_SRC*ADDR_W-1:0]  r_raddr;
  logic [NUM_SRC-1:0]         r_need;
  logic [CNT_W-1:0]           r_stall_cnt;

  // Resolution and handshake
  logic [NUM_SRC-1:0][NUM_FWD-1:0] w_hit;
  logic [NUM_SRC-1:0]              w_hazard;
  logic [NUM_SRC*DATA_W-1:0]       w_rdata;
  logic                            w_ready_go;
  logic                            w_load;
  logic                            w_stall_cycle;

  // Hit matrix: a source matches a forwarding entry only when it is really read and not r0
  always_comb begin
    w_hit = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = 0; i < NUM_FWD; i++) begin
        w_hit[s][i] = r_valid & r_need[s]
                    & (r_raddr[s*ADDR_W +: ADDR_W] != '0)
                    & fwd_we[i]
                    & (fwd_waddr[i*ADDR_W +: ADDR_W] == r_raddr[s*ADDR_W +: ADDR_W]);
      end
    end
  end

`ifdef FWD_EN
  // Full bypass: walk from oldest to youngest so the lowest hitting index wins
  always_comb begin
    w_rdata  = rf_rdata;
    w_hazard = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (w_hit[s][i]) begin
          w_rdata[s*DATA_W +: DATA_W] = fwd_wdata[i*DATA_W +: DATA_W];
          w_hazard[s]                 = ~fwd_ready[i];
        end
      end
    end
  end
`else
  // WB-only bypass: covers the register file's missing write-through; younger hits wait
  always_comb begin
    w_rdata  = rf_rdata;
    w_hazard = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (w_hit[s][WB_IDX]) begin
        w_rdata[s*DATA_W +: DATA_W] = fwd_wdata[WB_IDX*DATA_W +: DATA_W];
      end
      for (int i = 0; i < NUM_FWD - 1; i++) begin
        if (w_hit[s][i]) begin
          w_hazard[s] = 1'b1;
        end
      end
    end
  end

  // Readiness and the younger data lanes are irrelevant without full forwarding
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_ready, fwd_wdata};
`endif

  // Handshake toward both neighbours
  assign w_ready_go    = ~|w_hazard;
  assign w_load        = in_valid & in_allowin & ~flush;
  assign w_stall_cycle = r_valid & ~w_ready_go & ~flush;

  assign out_valid   = r_valid & w_ready_go;
  assign in_allowin  = ~r_valid | (w_ready_go & out_allowin);
  assign out_payload = r_payload;
  assign out_rdata   = w_rdata;
  assign rf_raddr    = r_raddr;
  assign stall_cnt   = r_stall_cnt;

  // Slot valid bit: reset, then flush, then normal pipeline advance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (in_allowin) begin
      r_valid <= in_valid;
    end
  end

  // Held instruction fields capture only on an accepted, non-flushed handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_payload <= '0;
      r_raddr   <= '0;
      r_need    <= '0;
    end else if (w_load) begin
      r_payload <= in_payload;
      r_raddr   <= in_raddr;
      r_need    <= in_need;
    end
  end

  // Saturating interlock counter; flush cycles are not interlocks
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall_cycle && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ds_operand_stage.sv
// tb_ds_operand_stage: scoreboard bench for ds_operand_stage (default parameters).
// Expected operands are queued when an instruction is sent and compared when it
// leaves toward EX; handshake and counter values are checked cycle by cycle.
// Expectations follow the FWD_EN macro the same way the design does.
module tb_ds_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int NF = 3;
  localparam int PW = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_allowin;
  logic [PW-1:0]     in_payload;
  logic [NS*AW-1:0]  in_raddr;
  logic [NS-1:0]     in_need;
  logic              flush;
  logic              out_valid;
  logic              out_allowin;
  logic [PW-1:0]     out_payload;
  logic [NS*DW-1:0]  out_rdata;
  logic [NS*AW-1:0]  rf_raddr;
  logic [NS*DW-1:0]  rf_rdata;
  logic [NF-1:0]     fwd_we;
  logic [NF*AW-1:0]  fwd_waddr;
  logic [NF*DW-1:0]  fwd_wdata;
  logic [NF-1:0]     fwd_ready;
  logic [31:0]       stall_cnt;

  always #5 clk = ~clk;

  ds_operand_stage #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .NUM_FWD(NF), .PAYLOAD_W(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_allowin(in_allowin), .in_payload(in_payload),
    .in_raddr(in_raddr), .in_need(in_need), .flush(flush),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_payload(out_payload),
    .out_rdata(out_rdata), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_ready(fwd_ready), .stall_cnt(stall_cnt)
  );

  // Register-file model: r0 reads zero, rN reads 0xA000_00NN
  function automatic logic [DW-1:0] rf_val(input logic [AW-1:0] a);
    return (a == '0) ? '0 : (32'hA000_0000 | DW'(a));
  endfunction

  always_comb begin
    rf_rdata = '0;
    for (int s = 0; s < NS; s++) rf_rdata[s*DW +: DW] = rf_val(rf_raddr[s*AW +: AW]);
  end

  typedef struct packed {
    logic [PW-1:0] pl;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_stall = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [PW-1:0] pl, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    exp_t e;
    e.pl = pl; e.d0 = d0; e.d1 = d1;
    sb_q.push_back(e);
  endtask

  // Pop and compare whenever the held instruction is handed to EX
  task automatic sb_poll();
    exp_t e;
    if (out_valid && out_allowin) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underrun: unexpected issue payload %h", out_payload);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_payload", 64'(out_payload), 64'(e.pl));
        check_eq("sb_rdata0", 64'(out_rdata[0 +: DW]), 64'(e.d0));
        check_eq("sb_rdata1", 64'(out_rdata[DW +: DW]), 64'(e.d1));
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    sb_poll();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_ready = '1;
  endtask

  task automatic set_fwd(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rdy);
    fwd_we[idx]              = 1'b1;
    fwd_waddr[idx*AW +: AW]  = a;
    fwd_wdata[idx*DW +: DW]  = d;
    fwd_ready[idx]           = rdy;
  endtask

  task automatic send(input logic [PW-1:0] pl, input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                      input logic [NS-1:0] need);
    in_valid = 1'b1; in_payload = pl; in_raddr = {a1, a0}; in_need = need;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_allowin = 1'b1;
    in_payload = '0; in_raddr = '0; in_need = '0;
    clear_fwd();

    // Reset held two cycles
    repeat (2) begin
      to_neg();
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_in_allowin", 64'(in_allowin), 64'd1);
      check_eq("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      to_pos();
    end
    check_eq("rst_payload", 64'(out_payload), 64'd0);
    check_eq("rst_rf_raddr", 64'(rf_raddr), 64'd0);
    reset = 1'b0;

    // No hits: operands come from the register file one cycle after accept
    send(64'h0000_0000_0000_1111, 5'd2, 5'd1, 2'b11);
    push_exp(64'h0000_0000_0000_1111, rf_val(5'd1), rf_val(5'd2));
    to_neg();
    check_eq("s1_in_allowin", 64'(in_allowin), 64'd1);
    to_pos();
    in_valid = 1'b0;
    to_neg();
    check_eq("s1_out_valid", 64'(out_valid), 64'd1);
    check_eq("s1_rf_raddr", 64'(rf_raddr), 64'({5'd2, 5'd1}));
    to_pos();

    // Two entries hit r4: index 0 must win
    send(64'h0000_0000_0000_2222, 5'd6, 5'd4, 2'b11);
    push_exp(64'h0000_0000_0000_2222, 32'h11, rf_val(5'd6));
    to_neg();
    to_pos();
    in_valid = 1'b0;
    set_fwd(0, 5'd4, 32'h11, 1'b1);
    set_fwd(1, 5'd4, 32'h22, 1'b1);
    to_neg();
`ifdef FWD_EN
    check_eq("s2_out_valid", 64'(out_valid), 64'd1);
    to_pos();
`else
    check_eq("s2_ex_hit_stall", 64'(out_valid), 64'd0);
    exp_stall++;
    to_pos();
    clear_fwd();
    set_fwd(2, 5'd4, 32'h11, 1'b1);
    to_neg();
    check_eq("s2_wb_out_valid", 64'(out_valid), 64'd1);
    to_pos();
`endif
    clear_fwd();
    check_eq("s2_stall_cnt", 64'(stall_cnt), 64'(exp_stall));

    // Load in EX for one cycle, then its value appears at index 1
    send(64'h0000_0000_0000_3333, 5'd5, 5'd5, 2'b01);
    push_exp(64'h0000_0000_0000_3333, 32'h33, rf_val(5'd5));
    to_neg();
    to_pos();
    in_valid = 1'b0;
    set_fwd(0, 5'd5, 32'hDEAD, 1'b0);
    to_neg();
    check_eq("s3_load_stall", 64'(out_valid), 64'd0);
    check_eq("s3_rf_raddr", 64'(rf_raddr), 64'({5'd5, 5'd5}));
    exp_stall++;
    to_pos();
    check_eq("s3_stall_cnt1", 64'(stall_cnt), 64'(exp_stall));
    clear_fwd();
    set_fwd(1, 5'd5, 32'h33, 1'b1);
    to_neg();
`ifdef FWD_EN
    check_eq("s3_mem_out_valid", 64'(out_valid), 64'd1);
`else
    check_eq("s3_mem_stall", 64'(out_valid), 64'd0);
    exp_stall++;
    to_pos();
    clear_fwd();
    set_fwd(2, 5'd5, 32'h33, 1'b1);
    to_neg();
    check_eq("s3_wb_out_valid", 64'(out_valid), 64'd1);
`endif
    to_pos();
    clear_fwd();
    check_eq("s3_stall_cnt2", 64'(stall_cnt), 64'(exp_stall));

    // r0 never hits and never stalls
    send(64'h0000_0000_0000_4444, 5'd0, 5'd0, 2'b11);
    push_exp(64'h0000_0000_0000_4444, 32'h0, 32'h0);
    to_neg();
    to_pos();
    in_valid = 1'b0;
    set_fwd(0, 5'd0, 32'h77, 1'b0);
    to_neg();
    check_eq("s4_r0_out_valid", 64'(out_valid), 64'd1);
    to_pos();
    clear_fwd();
    check_eq("s4_stall_cnt", 64'(stall_cnt), 64'(exp_stall));

    // EX back-pressure: operands valid but not taken
    send(64'h0000_0000_0000_8888, 5'd3, 5'd2, 2'b11);
    push_exp(64'h0000_0000_0000_8888, rf_val(5'd2), rf_val(5'd3));
    to_neg();
    to_pos();
    in_valid = 1'b0;
    out_allowin = 1'b0;
    to_neg();
    check_eq("s6_bp_out_valid", 64'(out_valid), 64'd1);
    check_eq("s6_bp_in_allowin", 64'(in_allowin), 64'd0);
    to_pos();
    out_allowin = 1'b1;
    to_neg();
    to_pos();

    // Youngest not ready while an older entry is ready: stall, then flush
    send(64'h0000_0000_0000_5555, 5'd0, 5'd7, 2'b01);
    to_neg();
    to_pos();
    in_valid = 1'b0;
    set_fwd(0, 5'd7, 32'hBAD, 1'b0);
    set_fwd(1, 5'd7, 32'h44, 1'b1);
    to_neg();
    check_eq("s5_prio_stall", 64'(out_valid), 64'd0);
    check_eq("s5_in_allowin", 64'(in_allowin), 64'd0);
    exp_stall++;
    to_pos();
    check_eq("s5_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    send(64'h0000_0000_0000_6666, 5'd1, 5'd1, 2'b11);
    flush = 1'b1;
    to_neg();
    check_eq("s5_flush_out_valid", 64'(out_valid), 64'd0);
    to_pos();
    flush = 1'b0;
    in_valid = 1'b0;
    clear_fwd();
    check_eq("s5_flush_no_count", 64'(stall_cnt), 64'(exp_stall));
    to_neg();
    check_eq("s5_empty_out_valid", 64'(out_valid), 64'd0);
    check_eq("s5_empty_in_allowin", 64'(in_allowin), 64'd1);
    to_pos();

    // Flush beats an upstream handshake into an empty slot
    send(64'h0000_0000_0000_7777, 5'd1, 5'd1, 2'b11);
    flush = 1'b1;
    to_neg();
    check_eq("s7_in_allowin", 64'(in_allowin), 64'd1);
    to_pos();
    flush = 1'b0;
    in_valid = 1'b0;
    to_neg();
    check_eq("s7_flush_out_valid", 64'(out_valid), 64'd0);
    check_eq("s7_payload_kept", 64'(out_payload), 64'h0000_0000_0000_5555);
    to_pos();

    // Reset mid-stall clears slot and counter
    send(64'h0000_0000_0000_9999, 5'd0, 5'd9, 2'b01);
    to_neg();
    to_pos();
    in_valid = 1'b0;
    set_fwd(0, 5'd9, 32'h99, 1'b0);
    to_neg();
    check_eq("s8_stall", 64'(out_valid), 64'd0);
    exp_stall++;
    to_pos();
    check_eq("s8_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    reset = 1'b1;
    to_neg();
    to_pos();
    reset = 1'b0;
    clear_fwd();
    exp_stall = 0;
    check_eq("s8_rst_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    to_neg();
    check_eq("s8_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("s8_rst_in_allowin", 64'(in_allowin), 64'd1);
    check_eq("s8_rst_payload", 64'(out_payload), 64'd0);
    to_pos();

    check_eq("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ds_operand_stage.md
# ds_operand_stage

Parametrised decode-stage operand unit for the five-stage LoongArch pipeline. It holds one decoded instruction in a valid/allowin pipeline slot and reads up to NUM_SRC source registers. Each source is resolved from an N-deep priority forwarding network or from the register file. The stage interlocks on sources that are not ready, such as a load in EX, honours a flush, and counts interlock cycles. It sits between the IF/decode front end and the EX stage and replaces the fixed 2-source, 3-stage bypass logic.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NUM_SRC, 2, number of source operands per instruction (1..4)
- NUM_FWD, 3, number of forwarding sources; index 0 is youngest (EX), index NUM_FWD-1 is WB
- PAYLOAD_W, 64, opaque decoded-instruction payload carried through the slot

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has an instruction
- in_allowin  out  1  stage accepts an instruction this cycle
- in_payload  in  PAYLOAD_W  decoded instruction payload
- in_raddr  in  NUM_SRC*ADDR_W  source addresses; source s occupies [s*ADDR_W +: ADDR_W]
- in_need  in  NUM_SRC  source s is actually read by the instruction
- flush  in  1  kill the held instruction (branch redirect)
- out_valid  out  1  instruction and operands valid toward EX
- out_allowin  in  1  EX accepts this cycle
- out_payload  out  PAYLOAD_W  held payload
- out_rdata  out  NUM_SRC*DATA_W  resolved operand values, packed the same way as in_raddr
- rf_raddr  out  NUM_SRC*ADDR_W  register-file read addresses; equal to the held addresses
- rf_rdata  in  NUM_SRC*DATA_W  register-file read data, combinational
- fwd_we  in  NUM_FWD  source i will write a register
- fwd_waddr  in  NUM_FWD*ADDR_W  destination address of source i
- fwd_wdata  in  NUM_FWD*DATA_W  result of source i
- fwd_ready  in  NUM_FWD  fwd_wdata[i] is final; 0 marks a load still in flight
- stall_cnt  out  32  saturating count of interlock cycles

## Operation
Slot registers:
- The slot holds `valid`, payload, raddr and need.
- Priority on each edge:
  - reset: valid←0, all held fields←0.
  - flush: valid←0.
  - in_allowin: valid←in_valid.
- Payload, raddr and need load when in_valid & in_allowin & ~flush.

Operand resolution, per source s:
- hit[i][s] = valid & need[s] & (raddr[s]≠0) & fwd_we[i] & (fwd_waddr[i]==raddr[s]).
- The lowest index i with a hit is selected.
- out_rdata[s] = fwd_wdata[selected i] when any hit exists, otherwise rf_rdata[s].
- hazard[s] = the selected hit has fwd_ready=0.

Handshake:
- ready_go = ~|hazard.
- out_valid = valid & ready_go.
- in_allowin = ~valid | (ready_go & out_allowin).
- The held instruction leaves when out_valid & out_allowin. If nothing loads, valid clears on the next edge.

Register r0 and sources with need=0 never hit and never stall. Their out_rdata is rf_rdata, so r0 reads 0.

Stall counter:
- Reset value 0.
- Increments by 1 on every cycle where valid & ~ready_go & ~flush.
- Holds at 0xFFFF_FFFF once reached.

## Timing
Reset values:
- Registered: valid=0, stall_cnt=0, held fields=0.
- Derived from those: out_valid=0, in_allowin=1, rf_raddr=0, out_payload=0.

Latency:
- An instruction accepted at edge N presents out_valid in cycle N+1 when there is no hazard.
- out_rdata is combinational in the same cycle as out_valid.

Boundary conditions:
- Flush and an upstream handshake in the same cycle: flush wins; valid=0 next cycle.
- Flush while stalled: the slot empties next cycle. stall_cnt does not count the flush cycle.
- Multiple sources hit the same address: the youngest, lowest index wins, including when an older source is ready and the youngest is not; that case stalls.
- A load in EX advances to MEM with fwd_ready=1: the hazard clears that same cycle and out_valid rises.
- Reset asserted mid-stall: the slot empties and the counter clears on that edge.

## Configuration
- FWD_EN defined: full forwarding as described above.
- FWD_EN undefined:
  - Any hit on indices 0..NUM_FWD-2 raises hazard regardless of fwd_ready.
  - Only index NUM_FWD-1 (WB) is bypassed into out_rdata, covering the register file's missing write-through.
  - The instruction therefore waits until its producer reaches WB.

## Test plan
- Reset held for 2 cycles → out_valid=0, in_allowin=1, stall_cnt=0. Release, then accept raddr={r2,r1} with no hits → the next cycle out_valid=1 and out_rdata equals rf_rdata.
- fwd_we={1,1,0}, both waddr=r4 (fwd_wdata 0x11 at index 0, 0x22 at index 1), fwd_ready=3'b111, source 0=r4 → out_rdata[0]=0x11 with no stall.
- Index 0 hits r5 with fwd_ready[0]=0 for 1 cycle, then the value is presented at index 1 with ready=1 → out_valid=0 for exactly 1 cycle, stall_cnt=1, then the operand equals the index-1 value.
- Source raddr=r0 with fwd_we[0]=1, fwd_waddr[0]=0, fwd_ready[0]=0 → no stall, out_rdata=0.
- Stalled instruction, then flush=1 and in_valid=1 in the same cycle → the next cycle valid=0, out_valid=0, stall_cnt unchanged.
- FWD_EN undefined, EX hit on r3 for 2 cycles, then the producer reaches WB with data 0x55 → 2 stall cycles, then out_rdata=0x55 and stall_cnt=2.
